id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
Pipeline register and operand-forwarding stage directly upstream of the 16-bit ALU. It latches decoded operands and control from ID, and drives input_A, input_B and ALU_Control into the ALU in EX, resolving RAW hazards by forwarding from EX/MEM and MEM/WB. It also detects load-use hazards and requests a one-cycle bubble.

Parameters:
DATA_WIDTH, 16, operand/result width; must match the ALU input_A/input_B/Result width
REG_ADDR_WIDTH, 3, register-number width (8 registers, r0 reads as zero)

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
stall  in  1  external hold: stage keeps its contents
flush  in  1  load a bubble on next edge (branch/jump redirect)
id_valid  in  1  ID holds a real instruction
id_rs_addr / id_rt_addr / id_rd_addr  in  REG_ADDR_WIDTH each  source A, source B, destination register
id_rs_data / id_rt_data / id_imm  in  DATA_WIDTH each  regfile read data and sign-extended immediate
id_ALU_Control  in  3  ALU opcode: 0 add, 1 sub, 5 and, 7 slt; others pass through unchanged
id_ALUSrc  in  1  1: B operand = immediate
id_ctrl  in  4  {RegWrite, MemRead, MemWrite, MemtoReg}
exmem_RegWrite / exmem_rd_addr / exmem_result  in  1 / REG_ADDR_WIDTH / DATA_WIDTH  EX/MEM forwarding source
memwb_RegWrite / memwb_rd_addr / memwb_result  in  1 / REG_ADDR_WIDTH / DATA_WIDTH  MEM/WB forwarding source
input_A / input_B  out  DATA_WIDTH each  ALU operands
ALU_Control  out  3  registered ALU opcode
ex_store_data  out  DATA_WIDTH  forwarded rt value, used for stores
ex_rd_addr / ex_ctrl / ex_valid  out  REG_ADDR_WIDTH / 4 / 1  registered destination, control and valid
load_use_stall  out  1  combinational: hold PC/IF/ID and bubble this stage

Behaviour:
- Reset: every register is cleared, so all outputs are 0, including ex_valid and load_use_stall.
- Update priority on each edge: reset > flush > stall > load_use_stall > normal load.
- flush: load a bubble. A bubble clears all registers to 0 (ALU_Control = 0, ex_ctrl = 0, ex_valid = 0).
- stall: addr, ctrl and ALU_Control registers hold their values.
  - The rs/rt data registers load their forwarded values, so a value forwarded while stalled is not lost when it leaves MEM/WB.
- load_use_stall is 1 when ex_valid & ex_ctrl.MemRead & id_valid & ex_rd_addr != 0 & (ex_rd_addr == id_rs_addr | ex_rd_addr == id_rt_addr).
  - While it is asserted, the next edge loads a bubble.
  - Upstream holds ID, so the dependent instruction enters one cycle later and receives the load data via MEM/WB forwarding.
- Normal load: latch all id_* values, with ex_valid = id_valid.
  - id_valid = 0 loads a bubble.
- Forwarding is combinational on the registered values, evaluated separately for rs and for rt:
  - use exmem_result if exmem_RegWrite & exmem_rd_addr == reg & reg != 0;
  - else use memwb_result if memwb_RegWrite & memwb_rd_addr == reg & reg != 0;
  - else use the latched data.
  - EX/MEM wins when both sources match. A source register of r0 always reads 0.
- input_A = forwarded rs. input_B = ALUSrc_q ? imm_q : forwarded rt. ex_store_data = forwarded rt (never the immediate).
- Latency: ID to ALU operands is 1 cycle. Forwarding adds no cycles. A load-use hazard costs exactly 1 bubble.

Optional Feature:
FORWARDING_EN:
- Defined: forwarding exactly as specified in Behaviour.
- Undefined: input_A, input_B and ex_store_data use the latched data only; the exmem_*/memwb_* inputs are ignored.
  - load_use_stall logic is unchanged; the compiler must schedule ALU-ALU dependencies itself.

Test Plan:
1. Reset for 2 cycles -> all outputs 0. Then id_rs_data=10, id_rt_data=20, id_ALU_Control=0, id_valid=1 -> next cycle input_A=10, input_B=20, ALU_Control=0, ex_valid=1.
2. Latched rs=r2, exmem_RegWrite=1, exmem_rd_addr=2, exmem_result=30; memwb also targets r2 with 99 -> input_A=30 (EX/MEM priority). With exmem_rd_addr=0 -> input_A=99.
3. ALUSrc=1, imm=6, forwarded rt=0x1234 -> input_B=6, ex_store_data=0x1234. Source register r0 with exmem_rd_addr=0, exmem_result=5 -> operand 0.
4. EX holds lw r3 and ID has add r4,r3,r1 -> load_use_stall=1 for exactly 1 cycle and ex_valid=0 next cycle. The add then enters and takes memwb_result=0x00FF as input_A.
5. stall=1 for 3 cycles while memwb forwards 42 to rs on the first cycle only -> input_A stays 42 through all 3 cycles. flush=1 together with stall=1 -> bubble (ex_valid=0, ex_ctrl=0).
6. Build without FORWARDING_EN, repeat test 2 -> input_A equals the latched rs data.

Source files
------------

// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: decoded operands and control from ID, forwarding sources
// from EX/MEM and MEM/WB, and the registered operands driven into the ALU.
// master = pipeline control / surrounding stages, slave = id_ex_stage.
interface id_ex_stage_if #(
  parameter int DATA_WIDTH     = 16,
  parameter int REG_ADDR_WIDTH = 3
);
  logic                      stall;
  logic                      flush;
  logic                      id_valid;
  logic [REG_ADDR_WIDTH-1:0] id_rs_addr;
  logic [REG_ADDR_WIDTH-1:0] id_rt_addr;
  logic [REG_ADDR_WIDTH-1:0] id_rd_addr;
  logic [DATA_WIDTH-1:0]     id_rs_data;
  logic [DATA_WIDTH-1:0]     id_rt_data;
  logic [DATA_WIDTH-1:0]     id_imm;
  logic [2:0]                id_ALU_Control;
  logic                      id_ALUSrc;
  logic [3:0]                id_ctrl;
  logic                      exmem_RegWrite;
  logic [REG_ADDR_WIDTH-1:0] exmem_rd_addr;
  logic [DATA_WIDTH-1:0]     exmem_result;
  logic                      memwb_RegWrite;
  logic [REG_ADDR_WIDTH-1:0] memwb_rd_addr;
  logic [DATA_WIDTH-1:0]     memwb_result;
  logic [DATA_WIDTH-1:0]     input_A;
  logic [DATA_WIDTH-1:0]     input_B;
  logic [2:0]                ALU_Control;
  logic [DATA_WIDTH-1:0]     ex_store_data;
  logic [REG_ADDR_WIDTH-1:0] ex_rd_addr;
  logic [3:0]                ex_ctrl;
  logic                      ex_valid;
  logic                      load_use_stall;

  modport master (
    output stall, flush, id_valid, id_rs_addr, id_rt_addr, id_rd_addr,
           id_rs_data, id_rt_data, id_imm, id_ALU_Control, id_ALUSrc, id_ctrl,
           exmem_RegWrite, exmem_rd_addr, exmem_result,
           memwb_RegWrite, memwb_rd_addr, memwb_result,
    input  input_A, input_B, ALU_Control, ex_store_data,
           ex_rd_addr, ex_ctrl, ex_valid, load_use_stall
  );

  modport slave (
    input  stall, flush, id_valid, id_rs_addr, id_rt_addr, id_rd_addr,
           id_rs_data, id_rt_data, id_imm, id_ALU_Control, id_ALUSrc, id_ctrl,
           exmem_RegWrite, exmem_rd_addr, exmem_result,
           memwb_RegWrite, memwb_rd_addr, memwb_result,
    output input_A, input_B, ALU_Control, ex_store_data,
           ex_rd_addr, ex_ctrl, ex_valid, load_use_stall
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding into the 16-bit ALU and
// load-use hazard detection (one-cycle bubble request).
// Build option: define FORWARDING_EN to enable EX/MEM and MEM/WB forwarding;
// without it the ALU operands come from the latched register-file data only.
module id_ex_stage #(
  parameter int DATA_WIDTH     = 16,
  parameter int REG_ADDR_WIDTH = 3
) (
  input logic          clk,
  input logic          reset,
  id_ex_stage_if.slave bus
);
  // id_ctrl = {RegWrite, MemRead, MemWrite, MemtoReg}
  localparam int CTRL_MEMREAD = 2;

  logic                      valid_q,    valid_d;
  logic [REG_ADDR_WIDTH-1:0] rs_addr_q,  rs_addr_d;
  logic [REG_ADDR_WIDTH-1:0] rt_addr_q,  rt_addr_d;
  logic [REG_ADDR_WIDTH-1:0] rd_addr_q,  rd_addr_d;
  logic [3:0]                ctrl_q,     ctrl_d;
  logic [2:0]                alu_ctrl_q, alu_ctrl_d;
  logic                      alu_src_q,  alu_src_d;
  logic [DATA_WIDTH-1:0]     rs_data_q,  rs_data_d;
  logic [DATA_WIDTH-1:0]     rt_data_q,  rt_data_d;
  logic [DATA_WIDTH-1:0]     imm_q,      imm_d;

  logic [DATA_WIDTH-1:0]     fwd_rs;
  logic [DATA_WIDTH-1:0]     fwd_rt;
  logic                      load_use;

`ifdef FORWARDING_EN
  // Operand selection: the younger EX/MEM result wins over MEM/WB; r0 never forwards.
  always_comb begin
    fwd_rs = rs_data_q;
    if (bus.exmem_RegWrite && (bus.exmem_rd_addr == rs_addr_q) && (rs_addr_q != '0))
      fwd_rs = bus.exmem_result;
    else if (bus.memwb_RegWrite && (bus.memwb_rd_addr == rs_addr_q) && (rs_addr_q != '0))
      fwd_rs = bus.memwb_result;

    fwd_rt = rt_data_q;
    if (bus.exmem_RegWrite && (bus.exmem_rd_addr == rt_addr_q) && (rt_addr_q != '0))
      fwd_rt = bus.exmem_result;
    else if (bus.memwb_RegWrite && (bus.memwb_rd_addr == rt_addr_q) && (rt_addr_q != '0))
      fwd_rt = bus.memwb_result;
  end
`else
  // Operand selection: latched register-file data only; ALU-ALU dependencies are
  // the compiler's problem in this build.
  always_comb begin
    fwd_rs = rs_data_q;
    fwd_rt = rt_data_q;
  end

  logic unused_fwd_src;
  assign unused_fwd_src = ^{bus.exmem_RegWrite, bus.exmem_rd_addr, bus.exmem_result,
                            bus.memwb_RegWrite, bus.memwb_rd_addr, bus.memwb_result};
`endif

  // Load in EX whose destination is a nonzero source of the instruction in ID.
  always_comb begin
    load_use = valid_q && ctrl_q[CTRL_MEMREAD] && bus.id_valid && (rd_addr_q != '0) &&
               ((rd_addr_q == bus.id_rs_addr) || (rd_addr_q == bus.id_rt_addr));
  end

  // Next-state: flush > stall > load-use bubble > normal load (reset is in the flop).
  always_comb begin
    valid_d    = valid_q;
    rs_addr_d  = rs_addr_q;
    rt_addr_d  = rt_addr_q;
    rd_addr_d  = rd_addr_q;
    ctrl_d     = ctrl_q;
    alu_ctrl_d = alu_ctrl_q;
    alu_src_d  = alu_src_q;
    rs_data_d  = rs_data_q;
    rt_data_d  = rt_data_q;
    imm_d      = imm_q;

    if (bus.flush || (!bus.stall && (load_use || !bus.id_valid))) begin
      valid_d    = 1'b0;
      rs_addr_d  = '0;
      rt_addr_d  = '0;
      rd_addr_d  = '0;
      ctrl_d     = '0;
      alu_ctrl_d = '0;
      alu_src_d  = 1'b0;
      rs_data_d  = '0;
      rt_data_d  = '0;
      imm_d      = '0;
    end else if (bus.stall) begin
      // Capture forwarded values so a result leaving MEM/WB during the hold is kept.
      rs_data_d = fwd_rs;
      rt_data_d = fwd_rt;
    end else begin
      valid_d    = 1'b1;
      rs_addr_d  = bus.id_rs_addr;
      rt_addr_d  = bus.id_rt_addr;
      rd_addr_d  = bus.id_rd_addr;
      ctrl_d     = bus.id_ctrl;
      alu_ctrl_d = bus.id_ALU_Control;
      alu_src_d  = bus.id_ALUSrc;
      rs_data_d  = bus.id_rs_data;
      rt_data_d  = bus.id_rt_data;
      imm_d      = bus.id_imm;
    end
  end

  // Pipeline register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q    <= 1'b0;
      rs_addr_q  <= '0;
      rt_addr_q  <= '0;
      rd_addr_q  <= '0;
      ctrl_q     <= '0;
      alu_ctrl_q <= '0;
      alu_src_q  <= 1'b0;
      rs_data_q  <= '0;
      rt_data_q  <= '0;
      imm_q      <= '0;
    end else begin
      valid_q    <= valid_d;
      rs_addr_q  <= rs_addr_d;
      rt_addr_q  <= rt_addr_d;
      rd_addr_q  <= rd_addr_d;
      ctrl_q     <= ctrl_d;
      alu_ctrl_q <= alu_ctrl_d;
      alu_src_q  <= alu_src_d;
      rs_data_q  <= rs_data_d;
      rt_data_q  <= rt_data_d;
      imm_q      <= imm_d;
    end
  end

  assign bus.input_A        = fwd_rs;
  assign bus.input_B        = alu_src_q ? imm_q : fwd_rt;
  assign bus.ex_store_data  = fwd_rt;
  assign bus.ALU_Control    = alu_ctrl_q;
  assign bus.ex_rd_addr     = rd_addr_q;
  assign bus.ex_ctrl        = ctrl_q;
  assign bus.ex_valid       = valid_q;
  assign bus.load_use_stall = load_use;
endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed scenarios followed by random
// traffic, all checked against a behavioural model of the stage.
module tb_id_ex_stage;
  typedef struct packed {
    logic        reset, stall, flush, idv;
    logic [2:0]  rs, rt, rd;
    logic [15:0] rsd, rtd, imm;
    logic [2:0]  alu;
    logic        src;
    logic [3:0]  ctrl;
    logic        xw;
    logic [2:0]  xrd;
    logic [15:0] xres;
    logic        ww;
    logic [2:0]  wrd;
    logic [15:0] wres;
  } in_t;

  // Instruction currently held in EX, as the model sees it.
  typedef struct packed {
    logic        v;
    logic [2:0]  rs, rt, rd;
    logic [3:0]  ctrl;
    logic [2:0]  alu;
    logic        src;
    logic [15:0] rsd, rtd, imm;
  } ex_t;

  typedef struct packed {
    logic [15:0] a, b, sd;
    logic [2:0]  alu, rd;
    logic [3:0]  ctrl;
    logic        v, lus;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  id_ex_stage_if #(.DATA_WIDTH(16), .REG_ADDR_WIDTH(3)) bus ();

  id_ex_stage #(.DATA_WIDTH(16), .REG_ADDR_WIDTH(3)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  int   errors = 0;
  int   checks = 0;
  exp_t sb_q[$];
  ex_t  ex_m;
  in_t  cur;
  bit   done = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Value an operand register has as seen in EX: newest in-flight producer first.
  function automatic logic [15:0] operand(input logic [2:0] r, input logic [15:0] latched,
                                          input in_t n);
    logic [15:0] val;
    val = latched;
`ifdef FORWARDING_EN
    if (r != 3'd0) begin
      if (n.ww && n.wrd == r) val = n.wres;
      if (n.xw && n.xrd == r) val = n.xres;
    end
`endif
    return val;
  endfunction

  function automatic logic hazard(input ex_t e, input in_t n);
    logic is_load;
    is_load = e.v && e.ctrl[2];
    return is_load && n.idv && e.rd != 3'd0 && (e.rd == n.rs || e.rd == n.rt);
  endfunction

  function automatic exp_t expect_of(input ex_t e, input in_t n);
    exp_t x;
    x.a    = operand(e.rs, e.rsd, n);
    x.sd   = operand(e.rt, e.rtd, n);
    x.b    = e.src ? e.imm : x.sd;
    x.alu  = e.alu;
    x.rd   = e.rd;
    x.ctrl = e.ctrl;
    x.v    = e.v;
    x.lus  = hazard(e, n);
    return x;
  endfunction

  // What the stage holds after a clock edge taken with inputs n.
  function automatic ex_t advance(input ex_t e, input in_t n);
    ex_t nx;
    nx = '0;
    if (n.reset || n.flush) return nx;
    if (n.stall) begin
      nx     = e;
      nx.rsd = operand(e.rs, e.rsd, n);
      nx.rtd = operand(e.rt, e.rtd, n);
      return nx;
    end
    if (hazard(e, n) || !n.idv) return nx;
    nx.v = 1'b1; nx.rs = n.rs; nx.rt = n.rt; nx.rd = n.rd;
    nx.ctrl = n.ctrl; nx.alu = n.alu; nx.src = n.src;
    nx.rsd = n.rsd; nx.rtd = n.rtd; nx.imm = n.imm;
    return nx;
  endfunction

  task automatic drive(input in_t n);
    reset              = n.reset;
    bus.stall          = n.stall;
    bus.flush          = n.flush;
    bus.id_valid       = n.idv;
    bus.id_rs_addr     = n.rs;
    bus.id_rt_addr     = n.rt;
    bus.id_rd_addr     = n.rd;
    bus.id_rs_data     = n.rsd;
    bus.id_rt_data     = n.rtd;
    bus.id_imm         = n.imm;
    bus.id_ALU_Control = n.alu;
    bus.id_ALUSrc      = n.src;
    bus.id_ctrl        = n.ctrl;
    bus.exmem_RegWrite = n.xw;
    bus.exmem_rd_addr  = n.xrd;
    bus.exmem_result   = n.xres;
    bus.memwb_RegWrite = n.ww;
    bus.memwb_rd_addr  = n.wrd;
    bus.memwb_result   = n.wres;
  endtask

  // One cycle: the edge consumes the previous inputs, then the next inputs go out.
  task automatic step(input in_t n);
    @(posedge clk);
    #1;
    ex_m = advance(ex_m, cur);
    cur  = n;
    drive(n);
    sb_q.push_back(expect_of(ex_m, n));
    #1;
  endtask

  // Monitor: compare every presented output against the oldest expectation.
  initial begin : monitor
    exp_t e;
    int   starve;
    starve = 0;
    forever begin
      @(negedge clk);
      if (sb_q.size() == 0) begin
        if (!done) begin
          starve++;
          if (starve > 20) begin
            checks++; errors++;
            $display("FAIL scoreboard_starved: got empty queue expected entries");
            starve = 0;
          end
        end
      end else begin
        starve = 0;
        e = sb_q.pop_front();
        chk("input_A",        bus.input_A,               e.a);
        chk("input_B",        bus.input_B,               e.b);
        chk("ex_store_data",  bus.ex_store_data,         e.sd);
        chk("ALU_Control",    {13'd0, bus.ALU_Control},  {13'd0, e.alu});
        chk("ex_rd_addr",     {13'd0, bus.ex_rd_addr},   {13'd0, e.rd});
        chk("ex_ctrl",        {12'd0, bus.ex_ctrl},      {12'd0, e.ctrl});
        chk("ex_valid",       {15'd0, bus.ex_valid},     {15'd0, e.v});
        chk("load_use_stall", {15'd0, bus.load_use_stall}, {15'd0, e.lus});
      end
    end
  end

  initial begin : stimulus
    in_t n;
    bit  fwd;
    int  budget;
`ifdef FORWARDING_EN
    fwd = 1'b1;
`else
    fwd = 1'b0;
`endif
    ex_m = '0;
    cur = '0;
    cur.reset = 1'b1;
    drive(cur);

    // Reset for two cycles, then a simple add.
    n = '0; n.reset = 1'b1;
    step(n);
    step(n);
    chk("reset_input_A", bus.input_A, 16'd0);
    chk("reset_ex_valid", {15'd0, bus.ex_valid}, 16'd0);
    n = '0; n.idv = 1'b1; n.rs = 3'd1; n.rt = 3'd2; n.rd = 3'd3;
    n.rsd = 16'd10; n.rtd = 16'd20; n.ctrl = 4'b1000;
    step(n);
    n = '0;
    step(n);
    chk("t1_input_A", bus.input_A, 16'd10);
    chk("t1_input_B", bus.input_B, 16'd20);
    chk("t1_ex_valid", {15'd0, bus.ex_valid}, 16'd1);

    // EX/MEM beats MEM/WB on the same register; then MEM/WB alone.
    n = '0; n.idv = 1'b1; n.rs = 3'd2; n.rsd = 16'd5; n.rd = 3'd4; n.ctrl = 4'b1000;
    step(n);
    n = '0; n.stall = 1'b1; n.xw = 1'b1; n.xrd = 3'd2; n.xres = 16'd30;
    n.ww = 1'b1; n.wrd = 3'd2; n.wres = 16'd99;
    step(n);
    chk("t2_exmem_priority", bus.input_A, fwd ? 16'd30 : 16'd5);
    n.xrd = 3'd0; n.xres = 16'd5;
    step(n);
    chk("t2_memwb", bus.input_A, fwd ? 16'd99 : 16'd5);

    // Immediate operand vs store data; r0 source never forwards.
    n = '0; n.idv = 1'b1; n.rs = 3'd0; n.rt = 3'd5; n.rtd = 16'h0111;
    n.src = 1'b1; n.imm = 16'd6; n.ctrl = 4'b0010;
    step(n);
    n = '0; n.stall = 1'b1; n.xw = 1'b1; n.xrd = 3'd0; n.xres = 16'd5;
    n.ww = 1'b1; n.wrd = 3'd5; n.wres = 16'h1234;
    step(n);
    chk("t3_input_B_imm", bus.input_B, 16'd6);
    chk("t3_store_data", bus.ex_store_data, fwd ? 16'h1234 : 16'h0111);
    chk("t3_r0_operand", bus.input_A, 16'd0);

    // Load-use: lw r3 in EX, add r4,r3,r1 in ID.
    n = '0; n.idv = 1'b1; n.rs = 3'd1; n.rd = 3'd3; n.rsd = 16'd100; n.ctrl = 4'b1101;
    step(n);
    n = '0; n.idv = 1'b1; n.rs = 3'd3; n.rt = 3'd1; n.rd = 3'd4; n.rsd = 16'd7;
    n.rtd = 16'd1; n.ctrl = 4'b1000;
    step(n);
    chk("t4_lus_asserted", {15'd0, bus.load_use_stall}, 16'd1);
    step(n);
    chk("t4_bubble_valid", {15'd0, bus.ex_valid}, 16'd0);
    chk("t4_lus_released", {15'd0, bus.load_use_stall}, 16'd0);
    n = '0; n.ww = 1'b1; n.wrd = 3'd3; n.wres = 16'h00FF;
    step(n);
    chk("t4_add_valid", {15'd0, bus.ex_valid}, 16'd1);
    chk("t4_load_fwd", bus.input_A, fwd ? 16'h00FF : 16'd7);

    // Stall holds a value forwarded only on the first stalled cycle.
    n = '0; n.idv = 1'b1; n.rs = 3'd2; n.rsd = 16'd1; n.rd = 3'd6; n.ctrl = 4'b1000;
    step(n);
    n = '0; n.stall = 1'b1; n.ww = 1'b1; n.wrd = 3'd2; n.wres = 16'd42;
    for (int i = 0; i < 3; i++) begin
      step(n);
      chk("t5_stall_hold", bus.input_A, fwd ? 16'd42 : 16'd1);
      n.ww = 1'b0;
    end
    n = '0; n.stall = 1'b1; n.flush = 1'b1;
    step(n);
    n = '0;
    step(n);
    chk("t5_flush_valid", {15'd0, bus.ex_valid}, 16'd0);
    chk("t5_flush_ctrl", {12'd0, bus.ex_ctrl}, 16'd0);

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      n = '0;
      n.reset = ($urandom_range(0, 63) == 0);
      n.stall = ($urandom_range(0, 7) == 0);
      n.flush = ($urandom_range(0, 15) == 0);
      n.idv   = ($urandom_range(0, 7) != 0);
      n.rs    = 3'($urandom_range(0, 7));
      n.rt    = 3'($urandom_range(0, 7));
      n.rd    = 3'($urandom_range(0, 7));
      n.rsd   = (n.rs == 3'd0) ? 16'd0 : 16'($urandom);
      n.rtd   = (n.rt == 3'd0) ? 16'd0 : 16'($urandom);
      n.imm   = 16'($urandom);
      n.alu   = 3'($urandom_range(0, 7));
      n.src   = 1'($urandom_range(0, 1));
      n.ctrl  = 4'($urandom_range(0, 15));
      n.xw    = 1'($urandom_range(0, 1));
      n.xrd   = 3'($urandom_range(0, 7));
      n.xres  = 16'($urandom);
      n.ww    = 1'($urandom_range(0, 1));
      n.wrd   = 3'($urandom_range(0, 7));
      n.wres  = 16'($urandom);
      step(n);
    end

    n = '0;
    step(n);
    done = 1;
    budget = 0;
    while (sb_q.size() != 0 && budget < 10) begin
      @(posedge clk);
      budget++;
    end
    if (sb_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
